regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: writeback controller in front of the integer register file.
//
// Purpose
//   Arbitrates the execute unit (EXU) and load unit (LSU) onto the single
//   register-file write port, with one cycle of latency through a registered
//   output stage. It also keeps a 32-entry busy scoreboard that decode uses
//   to stall on RAW/WAW hazards against results that have not been written yet.
//
// Configuration
//   REGFILE_WB_RR_ARB_EN  defined   : round-robin arbitration on contention
//                         undefined : fixed priority, LSU over EXU (default)
//   REG_WIDTH defaults to `REG_WIDTH (QianTang_header); 64 if not provided.
//
// Ports
//   clk_sys_i, rst_n_i            clock, synchronous active-low reset
//   exu_valid_i/exu_ready_o       EXU writeback handshake, exu_rd_i/exu_data_i
//   lsu_valid_i/lsu_ready_o       LSU writeback handshake, lsu_rd_i/lsu_data_i
//   rd_addr_o/rd_wen_o/result_o   register-file write port
//   issue_valid_i/issue_rd_i      decode issuing an instruction writing issue_rd_i
//   rs1_addr_i/rs2_addr_i         decode source operands under check
//   stall_o                       decode must hold
//   flush_i                       pipeline flush (clears scoreboard)

`ifndef REG_WIDTH
`define REG_WIDTH 64
`endif

module regfile_wb_ctrl #(
  parameter int unsigned REG_WIDTH = `REG_WIDTH
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_n_i,
  input  logic                 exu_valid_i,
  output logic                 exu_ready_o,
  input  logic [4:0]           exu_rd_i,
  input  logic [REG_WIDTH-1:0] exu_data_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_rd_i,
  input  logic [REG_WIDTH-1:0] lsu_data_i,
  output logic [4:0]           rd_addr_o,
  output logic                 rd_wen_o,
  output logic [REG_WIDTH-1:0] result_o,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  output logic                 stall_o,
  input  logic                 flush_i
);

  logic exu_gnt;
  logic lsu_gnt;

`ifdef REGFILE_WB_RR_ARB_EN
  // Pointer names the requester that wins the next contended cycle.
  typedef enum logic {
    FAV_LSU = 1'b0,
    FAV_EXU = 1'b1
  } rr_e;

  rr_e rr_q;
  rr_e rr_d;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      rr_q <= FAV_LSU;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Any grant, contended or not, hands priority to the other requester.
  always_comb begin
    rr_d = rr_q;
    if (lsu_gnt) begin
      rr_d = FAV_EXU;
    end else if (exu_gnt) begin
      rr_d = FAV_LSU;
    end
  end

  always_comb begin
    lsu_gnt = 1'b0;
    exu_gnt = 1'b0;
    if (rst_n_i) begin
      if (lsu_valid_i && exu_valid_i) begin
        lsu_gnt = (rr_q == FAV_LSU);
        exu_gnt = (rr_q == FAV_EXU);
      end else begin
        lsu_gnt = lsu_valid_i;
        exu_gnt = exu_valid_i;
      end
    end
  end
`else
  always_comb begin
    lsu_gnt = rst_n_i & lsu_valid_i;
    exu_gnt = rst_n_i & exu_valid_i & ~lsu_valid_i;
  end
`endif

  assign exu_ready_o = exu_gnt;
  assign lsu_ready_o = lsu_gnt;

  // Output stage: one commit per cycle, latency one.
  logic                 wen_q;
  logic                 wen_d;
  logic [4:0]           addr_q;
  logic [4:0]           addr_d;
  logic [REG_WIDTH-1:0] data_q;
  logic [REG_WIDTH-1:0] data_d;

  // A granted rd=0 request is consumed but never drives the write enable.
  always_comb begin
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (lsu_gnt) begin
      wen_d  = (lsu_rd_i != '0);
      addr_d = lsu_rd_i;
      data_d = lsu_data_i;
    end else if (exu_gnt) begin
      wen_d  = (exu_rd_i != '0);
      addr_d = exu_rd_i;
      data_d = exu_data_i;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rd_wen_o  = wen_q;
  assign rd_addr_o = addr_q;
  assign result_o  = data_q;

  // Busy scoreboard.
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic        stall;

  // Bit 0 is never set, so address 0 can never cause a stall.
  always_comb begin
    stall = ~rst_n_i
          | busy_q[rs1_addr_i]
          | busy_q[rs2_addr_i]
          | (issue_valid_i & busy_q[issue_rd_i]);
  end

  assign stall_o = stall;

  // Clear for the visible commit is applied before the issue set so that a
  // same-register issue in the commit cycle leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wen_q) begin
        busy_d[addr_q] = 1'b0;
      end
      if (issue_valid_i && !stall && (issue_rd_i != '0)) begin
        busy_d[issue_rd_i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus a
// randomized run against a behavioural model (set of busy registers, the
// last-granted requester and the commit expected in the current cycle).
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [63:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic [63:0] result;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2;
  logic        stall;
  logic        flush;

  int unsigned total = 0;
  int unsigned bad   = 0;

  regfile_wb_ctrl #(.REG_WIDTH(64)) dut (
    .clk_sys_i    (clk),
    .rst_n_i      (rst_n),
    .exu_valid_i  (exu_valid),
    .exu_ready_o  (exu_ready),
    .exu_rd_i     (exu_rd),
    .exu_data_i   (exu_data),
    .lsu_valid_i  (lsu_valid),
    .lsu_ready_o  (lsu_ready),
    .lsu_rd_i     (lsu_rd),
    .lsu_data_i   (lsu_data),
    .rd_addr_o    (rd_addr),
    .rd_wen_o     (rd_wen),
    .result_o     (result),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .rs1_addr_i   (rs1),
    .rs2_addr_i   (rs2),
    .stall_o      (stall),
    .flush_i      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model state.
  bit [31:0] m_busy;
  bit        m_last_exu;   // reset favours LSU, i.e. EXU counts as last granted
  bit        m_wen;
  bit [4:0]  m_addr;
  bit [63:0] m_res;

  // {exu_granted, lsu_granted} for the current inputs.
  function automatic bit [1:0] m_grant();
    if (!rst_n) return 2'b00;
    if (lsu_valid && exu_valid) begin
`ifdef REGFILE_WB_RR_ARB_EN
      return m_last_exu ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return {exu_valid, lsu_valid};
  endfunction

  function automatic bit m_stall();
    if (!rst_n) return 1'b1;
    return (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]) ||
           (issue_valid && issue_rd != 0 && m_busy[issue_rd]);
  endfunction

  // Advance one clock and the model alongside it; returns at posedge+1.
  task automatic tick();
    bit [1:0] g;
    bit       st;
    g  = m_grant();
    st = m_stall();
    @(posedge clk);
    if (!rst_n) begin
      m_busy = '0; m_last_exu = 1'b1; m_wen = 1'b0; m_addr = '0; m_res = '0;
    end else begin
      if (flush) m_busy = '0;
      else begin
        if (m_wen) m_busy[m_addr] = 1'b0;
        if (issue_valid && !st && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
      if (g[0]) begin
        m_wen = (lsu_rd != 0); m_addr = lsu_rd; m_res = lsu_data; m_last_exu = 1'b0;
      end else if (g[1]) begin
        m_wen = (exu_rd != 0); m_addr = exu_rd; m_res = exu_data; m_last_exu = 1'b1;
      end else begin
        m_wen = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    exu_valid = 1; exu_rd = 3; lsu_valid = 1; lsu_rd = 4;
    #1;
    total++; if (exu_ready !== 1'b0) begin bad++; $display("FAIL rst_exu_ready got=%b exp=0", exu_ready); end
    total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL rst_lsu_ready got=%b exp=0", lsu_ready); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b exp=1", stall); end
    tick();
    total++; if (rd_wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b exp=0", rd_wen); end
    total++; if (rd_addr !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", rd_addr); end
    total++; if (result !== 64'd0) begin bad++; $display("FAIL rst_result got=%h exp=0", result); end
    rst_n = 1; idle();
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL post_rst_stall got=%b exp=0", stall); end
  endtask

  task automatic test_exu_single();
    idle();
    exu_valid = 1; exu_rd = 5; exu_data = 64'h1234;
    #1;
    total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL exu1_ready got=%b exp=1", exu_ready); end
    total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL exu1_lsu_ready got=%b exp=0", lsu_ready); end
    tick();
    idle();
    #1;
    total++; if (rd_wen !== 1'b1) begin bad++; $display("FAIL exu1_wen got=%b exp=1", rd_wen); end
    total++; if (rd_addr !== 5'd5) begin bad++; $display("FAIL exu1_addr got=%0d exp=5", rd_addr); end
    total++; if (result !== 64'h1234) begin bad++; $display("FAIL exu1_result got=%h exp=1234", result); end
    tick();
    total++; if (rd_wen !== 1'b0) begin bad++; $display("FAIL exu1_wen_after got=%b exp=0", rd_wen); end
  endtask

  task automatic test_arbitration();
    bit exp_lsu;
    do_reset();
    exu_valid = 1; exu_rd = 1; exu_data = 64'hE;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 64'hD;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef REGFILE_WB_RR_ARB_EN
      exp_lsu = (i % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      total++; if (lsu_ready !== exp_lsu) begin bad++; $display("FAIL arb_lsu_ready[%0d] got=%b exp=%b", i, lsu_ready, exp_lsu); end
      total++; if (exu_ready !== !exp_lsu) begin bad++; $display("FAIL arb_exu_ready[%0d] got=%b exp=%b", i, exu_ready, !exp_lsu); end
      tick();
      total++; if (rd_addr !== (exp_lsu ? 5'd2 : 5'd1)) begin bad++; $display("FAIL arb_addr[%0d] got=%0d exp=%0d", i, rd_addr, exp_lsu ? 2 : 1); end
    end
    idle();
    tick();
  endtask

  task automatic test_raw_stall();
    idle();
    issue_valid = 1; issue_rd = 10;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_issue_stall got=%b exp=0", stall); end
    tick();
    idle(); rs1 = 10;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_a got=%b exp=1", stall); end
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_b got=%b exp=1", stall); end
    exu_valid = 1; exu_rd = 10; exu_data = 64'h55;
    #1;
    total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL raw_exu_ready got=%b exp=1", exu_ready); end
    tick();
    exu_valid = 0;
    #1;
    total++; if (rd_wen !== 1'b1 || rd_addr !== 5'd10) begin bad++; $display("FAIL raw_commit got=%b/%0d exp=1/10", rd_wen, rd_addr); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_commit got=%b exp=1", stall); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_stall_release got=%b exp=0", stall); end
    idle();
  endtask

  task automatic test_set_over_clear();
    idle();
    exu_valid = 1; exu_rd = 7; exu_data = 64'h77;
    tick();
    exu_valid = 0; issue_valid = 1; issue_rd = 7;
    #1;
    total++; if (rd_wen !== 1'b1 || rd_addr !== 5'd7) begin bad++; $display("FAIL soc_commit got=%b/%0d exp=1/7", rd_wen, rd_addr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL soc_issue_stall got=%b exp=0", stall); end
    tick();
    idle(); rs1 = 7;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL soc_busy7 got=%b exp=1", stall); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    issue_valid = 1; issue_rd = 3;  tick();
    issue_rd = 9;                   tick();
    issue_rd = 12; exu_valid = 1; exu_rd = 20; exu_data = 64'hAB; tick();
    idle();
    flush = 1; rs1 = 3; issue_valid = 1; issue_rd = 15;
    lsu_valid = 1; lsu_rd = 21; lsu_data = 64'hCD;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_pre_stall got=%b exp=1", stall); end
    total++; if (rd_wen !== 1'b1 || rd_addr !== 5'd20) begin bad++; $display("FAIL flush_inflight got=%b/%0d exp=1/20", rd_wen, rd_addr); end
    total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL flush_lsu_ready got=%b exp=1", lsu_ready); end
    tick();
    idle(); rs1 = 3;
    #1;
    total++; if (rd_wen !== 1'b1 || rd_addr !== 5'd21 || result !== 64'hCD) begin bad++; $display("FAIL flush_commit got=%b/%0d/%h exp=1/21/cd", rd_wen, rd_addr, result); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_clr3 got=%b exp=0", stall); end
    rs1 = 9; rs2 = 12; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_clr9_12 got=%b exp=0", stall); end
    rs1 = 15; rs2 = 7; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_ignored_issue got=%b exp=0", stall); end
    tick();
    idle();
  endtask

  task automatic test_rd0_and_reset();
    idle();
    exu_valid = 1; exu_rd = 0; exu_data = 64'h99;
    #1;
    total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL rd0_ready got=%b exp=1", exu_ready); end
    tick();
    exu_valid = 0;
    #1;
    total++; if (rd_wen !== 1'b0) begin bad++; $display("FAIL rd0_wen got=%b exp=0", rd_wen); end
    exu_valid = 1; exu_rd = 4; exu_data = 64'h44;
    tick();
    idle();
    rst_n = 0; lsu_valid = 1; lsu_rd = 6; lsu_data = 64'h66;
    #1;
    total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL midrst_lsu_ready got=%b exp=0", lsu_ready); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL midrst_stall got=%b exp=1", stall); end
    tick();
    total++; if (rd_wen !== 1'b0 || rd_addr !== 5'd0 || result !== 64'd0) begin bad++; $display("FAIL midrst_outputs got=%b/%0d/%h exp=0/0/0", rd_wen, rd_addr, result); end
    rst_n = 1; idle();
    tick();
  endtask

  task automatic test_random();
    bit       e_hold, l_hold;
    bit [1:0] g;
    bit       st;
    e_hold = 0; l_hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (!e_hold) begin
        exu_valid = ($urandom_range(0, 1) == 1);
        exu_rd = 5'($urandom_range(0, 15));
        exu_data = {$urandom, $urandom};
      end
      if (!l_hold) begin
        lsu_valid = ($urandom_range(0, 1) == 1);
        lsu_rd = 5'($urandom_range(0, 15));
        lsu_data = {$urandom, $urandom};
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd = 5'($urandom_range(0, 15));
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 79) != 0);
      #1;
      g  = m_grant();
      st = m_stall();
      total++; if (exu_ready !== g[1]) begin bad++; $display("FAIL rnd_exu_ready[%0d] got=%b exp=%b", i, exu_ready, g[1]); end
      total++; if (lsu_ready !== g[0]) begin bad++; $display("FAIL rnd_lsu_ready[%0d] got=%b exp=%b", i, lsu_ready, g[0]); end
      total++; if (stall !== st) begin bad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, stall, st); end
      tick();
      e_hold = exu_valid && !g[1];
      l_hold = lsu_valid && !g[0];
      total++; if (rd_wen !== m_wen) begin bad++; $display("FAIL rnd_wen[%0d] got=%b exp=%b", i, rd_wen, m_wen); end
      if (m_wen) begin
        total++; if (rd_addr !== m_addr || result !== m_res) begin bad++; $display("FAIL rnd_commit[%0d] got=%0d/%h exp=%0d/%h", i, rd_addr, result, m_addr, m_res); end
      end
    end
    rst_n = 1; idle();
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle();
    m_busy = '0; m_last_exu = 1'b1; m_wen = 1'b0; m_addr = '0; m_res = '0;
    test_reset();
    test_exu_single();
    test_arbitration();
    test_raw_stall();
    test_set_over_clear();
    test_flush();
    test_rd0_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
